keypad_scan_debounce: RTL and testbench
=======================================

Name: keypad_scan_debounce

Overview:
Parametrised keypad scanner with an integrated synchroniser, debouncer, multi-key rejection and release tracking. It drives one keypad row at a time and samples the active-low column lines. On a debounced single-key press it emits a one-cycle key_valid pulse with the encoded row and column. It sits between the keypad pins and the key-decode/display logic, and replaces the fixed 4x4 scanner.

Parameters:
NUM_ROWS, 4, number of keypad rows driven (>=2)
NUM_COLS, 4, number of column inputs sampled (>=2)
DWELL_CYCLES, 16, clocks each row is driven while idle-scanning (>=4; covers settling plus synchroniser latency)
DEBOUNCE_CYCLES, 8, consecutive stable clocks required to accept a press or a release (>=2)
ROW_ACTIVE_HIGH, 1, 1 = driven row is high and others low; 0 = inverted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
columns  in  NUM_COLS  raw keypad columns; active-low, idle all-ones
rows  out  NUM_ROWS  one-hot row drive; row index i drives bit NUM_ROWS-1-i
key_valid  out  1  one-cycle pulse on an accepted single-key press
key_row  out  $clog2(NUM_ROWS)  row index of the last accepted key
key_col  out  $clog2(NUM_COLS)  column index of the last accepted key (bit j low -> j)
key_code  out  RW+CW  {key_row, key_col}
key_held  out  1  high while the accepted key stays pressed
multi_key  out  1  one-cycle pulse when a debounced press has more than one column low

Behaviour:
- Reset values: state SCAN, row index 0, rows = row 0 drive (4'b1000 at defaults), dwell/debounce counters 0, synchroniser all-ones. key_valid, key_row, key_col, key_code, key_held and multi_key are all 0. Reset acts immediately from any state, including HELD.
- Columns pass through a 2-flop synchroniser (reset to all-ones). Define pressed = ~col_sync.
- SCAN:
  - The dwell counter runs 0..DWELL_CYCLES-1. pressed is sampled only when the counter is at DWELL_CYCLES-1.
  - If pressed != 0 at that sample: capture snapshot = pressed, clear the debounce counter, go to DEB_PRESS. The row stays the same.
  - Otherwise advance the row index, wrapping NUM_ROWS-1 -> 0, and clear the dwell counter.
- DEB_PRESS:
  - If pressed != snapshot: return to SCAN on the same row with the dwell counter cleared.
  - Otherwise, when the debounce counter reaches DEBOUNCE_CYCLES-1, go to HELD.
    - If popcount(snapshot) == 1: latch key_row, key_col and key_code, and pulse key_valid.
    - If popcount(snapshot) > 1: pulse multi_key. Key outputs are unchanged and key_held stays 0.
- HELD:
  - key_held = 1 only if entered with a single key.
  - Changes to pressed other than pressed == 0 are ignored (no new key_valid).
  - When pressed == 0, go to DEB_RELEASE with the counter cleared.
- DEB_RELEASE:
  - If pressed != 0: return to HELD without a new pulse.
  - After DEBOUNCE_CYCLES consecutive cycles of pressed == 0: go to SCAN, advance the row index and clear the dwell counter. key_held drops on entry to SCAN.
- Latency: if the sample at cycle T detects a press that then stays stable, key_valid is high in cycle T+1+DEBOUNCE_CYCLES, which is the first HELD cycle. Pulses are registered and exactly one cycle wide.
- Key outputs hold their value until the next accepted single key.
- rows stays one-hot (per ROW_ACTIVE_HIGH polarity) in every state.
- Exactly one key_valid is produced per press/release cycle, regardless of bounce.

Decomposition:
- Shared package keypad_pkg holds:
  - scan_state_t enum {SCAN, DEB_PRESS, HELD, DEB_RELEASE}
  - a width helper function for RW/CW
- One sub-module: col_sync, a parametrised-width 2-flop synchroniser with asynchronous active-low reset to all-ones.

Test Plan:
All scenarios use default parameters. The bench keypad model pulls column j low when key (r,j) is pressed and row r is driven.
- Idle wrap: no keys for 64 cycles after reset -> rows steps 1000, 0100, 0010, 0001, 1000, each for 16 cycles; no pulses.
- Clean press of key (2,1), then release: key_valid high for exactly 1 cycle, T+9 after detection; key_code = 4'b1001; key_held high until 8 cycles after release, then scanning resumes at row 3.
- Bouncy press: column toggles every 3 cycles for 20 cycles, then stays low -> exactly one key_valid, with correct code. Bouncy release (4-cycle glitches) -> no second key_valid.
- Two keys in one row, columns = 4'b1010 -> one multi_key pulse, no key_valid, key_held = 0, key_code keeps its previous value.
- Press (0,3), keep holding it, then add (0,0) -> no additional pulse. Release both, then press (3,2) -> second key_valid with key_code = 4'b1110.
- Assert reset low asynchronously mid-HELD, between clock edges -> all outputs 0 and rows = 4'b1000 before the next edge; after reset is released, normal scanning resumes.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad scanner.
//   scan_state_t : scanner FSM states
//   idx_width()  : bit width needed to index n items (at least 1)
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } scan_state_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/col_sync.sv
// col_sync: two-flop synchroniser for the raw keypad column lines.
// Both stages reset to all-ones, which is the idle (no key) level of the
// active-low columns, so no phantom press is seen coming out of reset.
// Ports:
//   clk   in          system clock
//   reset in          asynchronous active-low reset
//   din   in  WIDTH   asynchronous column inputs
//   dout  out WIDTH   synchronised columns
module col_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      dout <= '1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: row-scanning keypad controller with column
// synchroniser, press/release debounce, multi-key rejection and hold tracking.
// Ports:
//   clk       in            system clock
//   reset     in            asynchronous active-low reset
//   columns   in  NUM_COLS  raw active-low columns (idle all-ones)
//   rows      out NUM_ROWS  one-hot row drive; row i drives bit NUM_ROWS-1-i
//   key_valid out           one-cycle pulse on an accepted single-key press
//   key_row   out           row index of the last accepted key
//   key_col   out           column index of the last accepted key
//   key_code  out           {key_row, key_col}
//   key_held  out           high while the accepted key stays pressed
//   multi_key out           one-cycle pulse on a debounced multi-column press
// The FSM state is kept in the signal 'state' (scan_state_t) for probing.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int DWELL_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter bit ROW_ACTIVE_HIGH = 1'b1
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [NUM_COLS-1:0]                                columns,
  output logic [NUM_ROWS-1:0]                                rows,
  output logic                                               key_valid,
  output logic [idx_width(NUM_ROWS)-1:0]                     key_row,
  output logic [idx_width(NUM_COLS)-1:0]                     key_col,
  output logic [idx_width(NUM_ROWS)+idx_width(NUM_COLS)-1:0] key_code,
  output logic                                               key_held,
  output logic                                               multi_key
);

  localparam int RW = idx_width(NUM_ROWS);
  localparam int CW = idx_width(NUM_COLS);
  localparam int DW = idx_width(DWELL_CYCLES);
  localparam int BW = idx_width(DEBOUNCE_CYCLES);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(NUM_ROWS - 1);

  // Row drive pattern for a given row index; row 0 is the MSB.
  function automatic logic [NUM_ROWS-1:0] row_drive(input logic [RW-1:0] idx);
    logic [NUM_ROWS-1:0] onehot;
    onehot = {1'b1, {(NUM_ROWS-1){1'b0}}} >> idx;
    return ROW_ACTIVE_HIGH ? onehot : ~onehot;
  endfunction

  // Index of the (single) low column; only meaningful for one-hot input.
  function automatic logic [CW-1:0] col_index(input logic [NUM_COLS-1:0] p);
    logic [CW-1:0] idx;
    idx = '0;
    for (int j = 0; j < NUM_COLS; j++) begin
      if (p[j]) idx = CW'(j);
    end
    return idx;
  endfunction

  logic [NUM_COLS-1:0] col_sync_q;
  logic [NUM_COLS-1:0] pressed;
  logic [NUM_COLS-1:0] snapshot;
  logic [RW-1:0]       row_idx;
  logic [RW-1:0]       row_next;
  logic [DW-1:0]       dwell_cnt;
  logic [BW-1:0]       deb_cnt;
  logic                single_key;
  scan_state_t         state;

  col_sync #(.WIDTH(NUM_COLS)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .din   (columns),
    .dout  (col_sync_q)
  );

  assign pressed    = ~col_sync_q;
  assign row_next   = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
  assign single_key = ($countones(snapshot) == 1);
  assign key_code   = {key_row, key_col};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      row_idx   <= '0;
      rows      <= row_drive('0);
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      snapshot  <= '0;
      key_valid <= 1'b0;
      key_row   <= '0;
      key_col   <= '0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_key <= 1'b0;
      case (state)
        SCAN: begin
          // Columns are only trusted at the end of the dwell, once the row
          // drive has settled and passed through the synchroniser.
          if (dwell_cnt == DWELL_LAST) begin
            if (pressed != '0) begin
              snapshot <= pressed;
              deb_cnt  <= '0;
              state    <= DEB_PRESS;
            end else begin
              row_idx   <= row_next;
              rows      <= row_drive(row_next);
              dwell_cnt <= '0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end

        DEB_PRESS: begin
          if (pressed != snapshot) begin
            // Bounce: rescan the same row from the start of its dwell.
            state     <= SCAN;
            dwell_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state <= HELD;
            if (single_key) begin
              key_row   <= row_idx;
              key_col   <= col_index(snapshot);
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end else begin
              multi_key <= 1'b1;
            end
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        HELD: begin
          // Any pattern change short of full release is ignored here.
          if (pressed == '0) begin
            deb_cnt <= '0;
            state   <= DEB_RELEASE;
          end
        end

        DEB_RELEASE: begin
          if (pressed != '0) begin
            state <= HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= SCAN;
            row_idx   <= row_next;
            rows      <= row_drive(row_next);
            dwell_cnt <= '0;
            key_held  <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
module tb_keypad_scan_debounce;

  logic       clk;
  logic       reset;
  logic [3:0] columns;
  logic [3:0] rows;
  logic       key_valid;
  logic [1:0] key_row;
  logic [1:0] key_col;
  logic [3:0] key_code;
  logic       key_held;
  logic       multi_key;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int kv_cnt      = 0;
  int mk_cnt      = 0;
  logic prev_kv   = 1'b0;
  logic prev_mk   = 1'b0;

  logic [15:0] key_mask;        // bit r*4+c = key (r,c) closed
  logic [3:0]  exp_q[$];        // expected key codes, in press order

  keypad_scan_debounce dut (
    .clk       (clk),
    .reset     (reset),
    .columns   (columns),
    .rows      (rows),
    .key_valid (key_valid),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_code  (key_code),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- keypad model ----------------
  always_comb begin
    columns = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && rows[3-r]) columns[c] = 1'b0;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] idle_rows(input int n);
    logic [3:0] base;
    base = 4'b1000;
    return base >> ((n / 16) % 4);
  endfunction

  function automatic logic [3:0] code_of(input int r, input int c);
    return 4'(r * 4 + c);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    key_mask[r*4+c] = v;
  endtask

  task automatic wait_kv(input int prev, input int budget);
    int n = 0;
    while (kv_cnt == prev && n < budget) begin step(); n++; end
    check("kv_arrival", 32'(kv_cnt != prev), 1);
  endtask

  task automatic wait_mk(input int prev, input int budget);
    int n = 0;
    while (mk_cnt == prev && n < budget) begin step(); n++; end
    check("mk_arrival", 32'(mk_cnt != prev), 1);
  endtask

  task automatic wait_held_low(input int budget);
    int n = 0;
    while (key_held !== 1'b0 && n < budget) begin step(); n++; end
    check("held_release", 32'(key_held), 0);
  endtask

  task automatic wait_rows(input logic [3:0] pat, input int budget);
    int n = 0;
    while (rows !== pat && n < budget) begin step(); n++; end
    check("rows_reach", 32'(rows), 32'(pat));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      check("rows_onehot", 32'($onehot(rows)), 1);
      if (key_valid) begin
        kv_cnt++;
        check("kv_width", 32'(prev_kv), 0);
        check("kv_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("kv_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
      if (multi_key) begin
        mk_cnt++;
        check("mk_width", 32'(prev_mk), 0);
      end
    end
    prev_kv = key_valid;
    prev_mk = multi_key;
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int kv0, mk0, r, c;
    reset    = 1'b0;
    key_mask = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rows", 32'(rows), 32'h8);
    check("rst_key_valid", 32'(key_valid), 0);
    check("rst_key_code", 32'(key_code), 0);
    check("rst_key_held", 32'(key_held), 0);
    check("rst_multi_key", 32'(multi_key), 0);
    reset = 1'b1;
    cyc   = 0;

    // Idle wrap: rows step every 16 cycles and wrap.
    check("idle_rows", 32'(rows), 32'(idle_rows(0)));
    while (cyc < 64) begin
      step();
      check("idle_rows", 32'(rows), 32'(idle_rows(cyc)));
    end
    check("idle_no_kv", 32'(kv_cnt), 0);
    check("idle_no_mk", 32'(mk_cnt), 0);

    // Clean press of (2,1): row 2 active from cycle 96, sampled at 111,
    // so key_valid is expected in cycle 111+1+8 = 120.
    while (cyc < 70) step();
    exp_q.push_back(code_of(2, 1));
    set_key(2, 1, 1'b1);
    while (cyc < 130) begin
      step();
      check("clean_kv", 32'(key_valid), 32'(cyc == 120));
      check("clean_held", 32'(key_held), 32'(cyc >= 120));
      check("clean_rows", 32'(rows), 32'((cyc <= 111) ? idle_rows(cyc) : 4'b0010));
      check("clean_code", 32'(key_code), 32'((cyc >= 120) ? 4'b1001 : 4'b0000));
    end
    set_key(2, 1, 1'b0);
    while (cyc < 136) begin
      step();
      check("release_held_on", 32'(key_held), 1);
    end
    while (cyc < 145) step();
    check("release_held_off", 32'(key_held), 0);
    check("release_next_row", 32'(rows), 32'h1);
    check("clean_kv_count", 32'(kv_cnt), 1);

    // Bouncy press of (1,2) while row 1 is driven, then bouncy release.
    wait_rows(4'b0100, 100);
    kv0 = kv_cnt;
    exp_q.push_back(code_of(1, 2));
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) key_mask[6] = ~key_mask[6];
      step();
    end
    set_key(1, 2, 1'b1);
    wait_kv(kv0, 200);
    check("bounce_code", 32'(key_code), 32'h6);
    repeat (20) step();
    for (int i = 0; i < 4; i++) begin
      set_key(1, 2, i[0]);
      repeat (4) step();
    end
    set_key(1, 2, 1'b0);
    wait_held_low(100);
    check("bounce_kv_count", 32'(kv_cnt), 32'(kv0 + 1));

    // Two keys in one row -> multi_key only.
    kv0 = kv_cnt;
    mk0 = mk_cnt;
    set_key(2, 0, 1'b1);
    set_key(2, 2, 1'b1);
    wait_mk(mk0, 200);
    check("multi_held", 32'(key_held), 0);
    check("multi_code_kept", 32'(key_code), 32'h6);
    repeat (20) step();
    check("multi_mk_count", 32'(mk_cnt), 32'(mk0 + 1));
    check("multi_held_later", 32'(key_held), 0);
    set_key(2, 0, 1'b0);
    set_key(2, 2, 1'b0);
    repeat (30) step();
    check("multi_no_kv", 32'(kv_cnt), 32'(kv0));

    // Hold (0,3), add (0,0): no extra pulses. Then (3,2).
    kv0 = kv_cnt;
    mk0 = mk_cnt;
    exp_q.push_back(code_of(0, 3));
    set_key(0, 3, 1'b1);
    wait_kv(kv0, 200);
    set_key(0, 0, 1'b1);
    repeat (40) step();
    check("hold_add_kv", 32'(kv_cnt), 32'(kv0 + 1));
    check("hold_add_mk", 32'(mk_cnt), 32'(mk0));
    check("hold_add_held", 32'(key_held), 1);
    check("hold_add_code", 32'(key_code), 32'h3);
    set_key(0, 3, 1'b0);
    set_key(0, 0, 1'b0);
    wait_held_low(100);
    kv0 = kv_cnt;
    exp_q.push_back(code_of(3, 2));
    set_key(3, 2, 1'b1);
    wait_kv(kv0, 200);
    check("second_code", 32'(key_code), 32'hE);
    set_key(3, 2, 1'b0);
    wait_held_low(100);

    // Randomised single presses against the scoreboard.
    for (int it = 0; it < 6; it++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      kv0 = kv_cnt;
      exp_q.push_back(code_of(r, c));
      set_key(r, c, 1'b1);
      wait_kv(kv0, 200);
      check("rand_row", 32'(key_row), 32'(r));
      check("rand_col", 32'(key_col), 32'(c));
      check("rand_held", 32'(key_held), 1);
      repeat ($urandom_range(1, 30)) step();
      set_key(r, c, 1'b0);
      wait_held_low(100);
      repeat ($urandom_range(0, 20)) step();
    end

    // Asynchronous reset in the middle of HELD.
    kv0 = kv_cnt;
    exp_q.push_back(code_of(1, 1));
    set_key(1, 1, 1'b1);
    wait_kv(kv0, 200);
    check("pre_reset_held", 32'(key_held), 1);
    #2;
    reset    = 1'b0;
    key_mask = '0;
    #1;
    check("async_rows", 32'(rows), 32'h8);
    check("async_held", 32'(key_held), 0);
    check("async_code", 32'(key_code), 0);
    check("async_kv", 32'(key_valid), 0);
    check("async_mk", 32'(multi_key), 0);
    repeat (2) step();
    reset = 1'b1;
    cyc   = 0;
    kv0   = kv_cnt;
    while (cyc < 40) begin
      step();
      check("post_reset_rows", 32'(rows), 32'(idle_rows(cyc)));
    end
    check("post_reset_no_kv", 32'(kv_cnt), 32'(kv0));
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
